// File: rtl/tt_um_jleugeri_ttt_token_accumulator.sv
// Per-processor saturating good/bad token accumulators. Pending entries drain
// round-robin through one registered valid/ready output slot.
module tt_um_jleugeri_ttt_token_accumulator #(
  parameter int NUM_PROCESSORS  = 4,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int ACC_BITS        = 8,
  localparam int ID_BITS        = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in,
  input  logic [ID_BITS-1:0]                target_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  input  logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [ID_BITS-1:0]                out_id,
  output logic signed [ACC_BITS-1:0]        out_good,
  output logic signed [ACC_BITS-1:0]        out_bad,
  output logic                              pending_any,
  output logic                              overflow
);

  function automatic logic [ACC_BITS-1:0] f_sext(input logic [NEW_TOKENS_BITS-1:0] d);
    return {{(ACC_BITS-NEW_TOKENS_BITS){d[NEW_TOKENS_BITS-1]}}, d};
  endfunction

  // Returns {clamped, value}; one guard bit suffices because |delta| < 2^(ACC_BITS-1).
  function automatic logic [ACC_BITS:0] f_sat_add(input logic [ACC_BITS-1:0] a,
                                                  input logic [ACC_BITS-1:0] d);
    logic [ACC_BITS:0] s;
    s = {a[ACC_BITS-1], a} + {d[ACC_BITS-1], d};
    if (s[ACC_BITS] != s[ACC_BITS-1])
      return {1'b1, s[ACC_BITS], {(ACC_BITS-1){~s[ACC_BITS]}}};
    return {1'b0, s[ACC_BITS-1:0]};
  endfunction

  logic [ACC_BITS-1:0]       r_acc_good [NUM_PROCESSORS];
  logic [ACC_BITS-1:0]       r_acc_bad  [NUM_PROCESSORS];
  logic [NUM_PROCESSORS-1:0] r_pending;
  logic [ID_BITS-1:0]        r_rr_ptr;
  logic                      r_out_valid;
  logic [ID_BITS-1:0]        r_out_id;
  logic [ACC_BITS-1:0]       r_out_good;
  logic [ACC_BITS-1:0]       r_out_bad;
  logic                      r_overflow;

  logic                      w_slot_free;
  logic                      w_found;
  logic                      w_load;
  logic [ID_BITS-1:0]        w_pick;
  logic [ID_BITS-1:0]        w_next_ptr;
  logic [ACC_BITS-1:0]       w_ext_good;
  logic [ACC_BITS-1:0]       w_ext_bad;
  logic [NUM_PROCESSORS-1:0] w_rot_pend;
  logic [NUM_PROCESSORS-1:0] w_hit;
  logic [NUM_PROCESSORS-1:0] w_take;
  logic [NUM_PROCESSORS-1:0] w_clamp;
  logic [NUM_PROCESSORS-1:0] w_pending_next;
  logic [ID_BITS-1:0]        w_rot_idx   [NUM_PROCESSORS];
  logic [ACC_BITS-1:0]       w_good_next [NUM_PROCESSORS];
  logic [ACC_BITS-1:0]       w_bad_next  [NUM_PROCESSORS];

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load      = w_slot_free && w_found;
  assign w_ext_good  = f_sext(new_good_tokens);
  assign w_ext_bad   = f_sext(new_bad_tokens);
  assign w_next_ptr  = (w_pick == ID_BITS'(NUM_PROCESSORS-1)) ? '0 : w_pick + ID_BITS'(1);

  // Pending flags viewed in search order starting at the round-robin pointer.
  for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_rot
    assign w_rot_idx[gi]  = ID_BITS'((int'(r_rr_ptr) + gi) % NUM_PROCESSORS);
    assign w_rot_pend[gi] = r_pending[w_rot_idx[gi]];
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < NUM_PROCESSORS; k++) begin
      if (!w_found && w_rot_pend[k]) begin
        w_found = 1'b1;
        w_pick  = w_rot_idx[k];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_lane
    logic [ACC_BITS:0] w_sum_good;
    logic [ACC_BITS:0] w_sum_bad;

    assign w_hit[gi]  = valid_in && (target_id == ID_BITS'(gi));
    assign w_take[gi] = w_load && (w_pick == ID_BITS'(gi));
    assign w_sum_good = f_sat_add(r_acc_good[gi], w_ext_good);
    assign w_sum_bad  = f_sat_add(r_acc_bad[gi], w_ext_bad);

    // On a collision the slot takes the old sum and the delta restarts the lane.
    assign w_good_next[gi] = w_take[gi] ? (w_hit[gi] ? w_ext_good : '0)
                                        : (w_hit[gi] ? w_sum_good[ACC_BITS-1:0] : r_acc_good[gi]);
    assign w_bad_next[gi]  = w_take[gi] ? (w_hit[gi] ? w_ext_bad : '0)
                                        : (w_hit[gi] ? w_sum_bad[ACC_BITS-1:0] : r_acc_bad[gi]);
    assign w_pending_next[gi] = w_hit[gi] || (r_pending[gi] && !w_take[gi]);
    assign w_clamp[gi] = w_hit[gi] && !w_take[gi] && (w_sum_good[ACC_BITS] || w_sum_bad[ACC_BITS]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        r_acc_good[i] <= '0;
        r_acc_bad[i]  <= '0;
      end
      r_pending   <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_good  <= '0;
      r_out_bad   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        r_acc_good[i] <= w_good_next[i];
        r_acc_bad[i]  <= w_bad_next[i];
      end
      r_pending  <= w_pending_next;
      r_overflow <= r_overflow || (|w_clamp);
      if (w_slot_free) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_id   <= w_pick;
          r_out_good <= r_acc_good[w_pick];
          r_out_bad  <= r_acc_bad[w_pick];
          r_rr_ptr   <= w_next_ptr;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_id      = r_out_id;
  assign out_good    = r_out_good;
  assign out_bad     = r_out_bad;
  assign pending_any = |r_pending;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_accumulator.sv
// Directed bench for the token accumulator: reset, latency, stall, saturation,
// round-robin order, collision and asynchronous reset.
module tb_tt_um_jleugeri_ttt_token_accumulator;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [1:0]        target_id;
  logic signed [3:0] new_good_tokens;
  logic signed [3:0] new_bad_tokens;
  logic              out_ready;
  logic              out_valid;
  logic [1:0]        out_id;
  logic signed [7:0] out_good;
  logic signed [7:0] out_bad;
  logic              pending_any;
  logic              overflow;

  int n_cmp = 0;
  int n_mis = 0;

  tt_um_jleugeri_ttt_token_accumulator #(
    .NUM_PROCESSORS(4), .NEW_TOKENS_BITS(4), .ACC_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .target_id(target_id),
    .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
    .out_ready(out_ready), .out_valid(out_valid), .out_id(out_id),
    .out_good(out_good), .out_bad(out_bad), .pending_any(pending_any),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] id, input logic [3:0] g, input logic [3:0] b);
    valid_in = 1'b1; target_id = id; new_good_tokens = g; new_bad_tokens = b;
    tick();
  endtask

  task automatic idle();
    valid_in = 1'b0; target_id = 2'd0; new_good_tokens = 4'd0; new_bad_tokens = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; idle();
    #1;
    n_cmp++; if ({out_valid, pending_any, overflow} !== 3'b000) begin n_mis++; $display("FAIL reset_flags: got %b expected 000", {out_valid, pending_any, overflow}); end
    repeat (2) tick();
    n_cmp++; if ({out_id, out_good, out_bad} !== 18'h0) begin n_mis++; $display("FAIL reset_slot: got %h expected 0", {out_id, out_good, out_bad}); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(2'd2, 4'd3, 4'hF);
    idle();
    n_cmp++; if ({out_valid, pending_any} !== 2'b01) begin n_mis++; $display("FAIL single_latency: got %b expected 01", {out_valid, pending_any}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd2, 8'd3, 8'hFF}) begin n_mis++; $display("FAIL single_slot: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd2, 8'd3, 8'hFF}); end
    tick();
    n_cmp++; if ({out_valid, pending_any} !== 2'b00) begin n_mis++; $display("FAIL single_drain: got %b expected 00", {out_valid, pending_any}); end
    $display("test_single done");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(2'd0, 4'd1, 4'd0);
    send(2'd1, 4'd7, 4'd0);
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd0, 8'd1, 8'd0}) begin n_mis++; $display("FAIL stall_load: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd0, 8'd1, 8'd0}); end
    send(2'd1, 4'd7, 4'd0);
    send(2'd1, 4'd7, 4'd0);
    idle();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad, pending_any} !== {1'b1, 2'd0, 8'd1, 8'd0, 1'b1}) begin n_mis++; $display("FAIL stall_hold: got %h expected %h", {out_valid, out_id, out_good, out_bad, pending_any}, {1'b1, 2'd0, 8'd1, 8'd0, 1'b1}); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd1, 8'd21, 8'd0}) begin n_mis++; $display("FAIL stall_release: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd1, 8'd21, 8'd0}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b0, 2'd1, 8'd21, 8'd0}) begin n_mis++; $display("FAIL stall_empty_hold: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b0, 2'd1, 8'd21, 8'd0}); end
    $display("test_stall done");
  endtask

  task automatic test_overflow();
    n_cmp++; if (overflow !== 1'b0) begin n_mis++; $display("FAIL ovf_initial: got %b expected 0", overflow); end
    out_ready = 1'b0;
    send(2'd0, 4'd2, 4'd0);
    for (int i = 0; i < 20; i++) send(2'd3, 4'd7, 4'h8);
    idle();
    n_cmp++; if ({overflow, out_valid, out_id, out_good} !== {1'b1, 1'b1, 2'd0, 8'd2}) begin n_mis++; $display("FAIL ovf_set: got %h expected %h", {overflow, out_valid, out_id, out_good}, {1'b1, 1'b1, 2'd0, 8'd2}); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd3, 8'h7F, 8'h80}) begin n_mis++; $display("FAIL ovf_clamped: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd3, 8'h7F, 8'h80}); end
    tick();
    n_cmp++; if ({out_valid, overflow} !== 2'b01) begin n_mis++; $display("FAIL ovf_sticky: got %b expected 01", {out_valid, overflow}); end
    $display("test_overflow done");
  endtask

  task automatic test_round_robin();
    out_ready = 1'b0;
    send(2'd3, 4'd1, 4'd0);
    send(2'd1, 4'd2, 4'd0);
    send(2'd0, 4'd3, 4'd0);
    send(2'd3, 4'd4, 4'd0);
    idle();
    n_cmp++; if ({out_valid, out_id, out_good, pending_any} !== {1'b1, 2'd3, 8'd1, 1'b1}) begin n_mis++; $display("FAIL rr_hold: got %h expected %h", {out_valid, out_id, out_good, pending_any}, {1'b1, 2'd3, 8'd1, 1'b1}); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, out_id, out_good} !== {1'b1, 2'd0, 8'd3}) begin n_mis++; $display("FAIL rr_first: got %h expected %h", {out_valid, out_id, out_good}, {1'b1, 2'd0, 8'd3}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good} !== {1'b1, 2'd1, 8'd2}) begin n_mis++; $display("FAIL rr_second: got %h expected %h", {out_valid, out_id, out_good}, {1'b1, 2'd1, 8'd2}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good} !== {1'b1, 2'd3, 8'd4}) begin n_mis++; $display("FAIL rr_third: got %h expected %h", {out_valid, out_id, out_good}, {1'b1, 2'd3, 8'd4}); end
    tick();
    n_cmp++; if ({out_valid, pending_any} !== 2'b00) begin n_mis++; $display("FAIL rr_drain: got %b expected 00", {out_valid, pending_any}); end
    $display("test_round_robin done");
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    send(2'd2, 4'd4, 4'hE);
    send(2'd2, 4'd5, 4'h8);
    idle();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd2, 8'd4, 8'hFE}) begin n_mis++; $display("FAIL coll_old: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd2, 8'd4, 8'hFE}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd2, 8'd5, 8'hF8}) begin n_mis++; $display("FAIL coll_new: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd2, 8'd5, 8'hF8}); end
    tick();
    n_cmp++; if ({out_valid, pending_any} !== 2'b00) begin n_mis++; $display("FAIL coll_drain: got %b expected 00", {out_valid, pending_any}); end
    $display("test_collision done");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(2'd1, 4'd3, 4'd0);
    send(2'd2, 4'd1, 4'd0);
    idle();
    n_cmp++; if ({out_valid, pending_any, overflow} !== 3'b111) begin n_mis++; $display("FAIL areset_pre: got %b expected 111", {out_valid, pending_any, overflow}); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({out_valid, pending_any, overflow} !== 3'b000) begin n_mis++; $display("FAIL areset_flags: got %b expected 000", {out_valid, pending_any, overflow}); end
    n_cmp++; if ({out_id, out_good, out_bad} !== 18'h0) begin n_mis++; $display("FAIL areset_slot: got %h expected 0", {out_id, out_good, out_bad}); end
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(2'd2, 4'd6, 4'd1);
    idle();
    n_cmp++; if ({out_valid, pending_any} !== 2'b01) begin n_mis++; $display("FAIL areset_fresh: got %b expected 01", {out_valid, pending_any}); end
    tick();
    n_cmp++; if ({out_valid, out_id, out_good, out_bad} !== {1'b1, 2'd2, 8'd6, 8'd1}) begin n_mis++; $display("FAIL areset_new: got %h expected %h", {out_valid, out_id, out_good, out_bad}, {1'b1, 2'd2, 8'd6, 8'd1}); end
    tick();
    n_cmp++; if ({out_valid, pending_any, overflow} !== 3'b000) begin n_mis++; $display("FAIL areset_drain: got %b expected 000", {out_valid, pending_any, overflow}); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_round_robin();
    test_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
